tx_packet_scheduler: RTL and testbench

// - Round-robin scheduler that shares one UDP/Ethernet packet generator among N_REQ payload sources.
// - Grants one requester and forwards that requester's payload AXI-Stream into the generator's payload input.
// - Presents the requester's header descriptor and launches the generator, then waits for the generator to finish.
// - Sits between per-flow payload FIFOs and the generator; one packet is in flight at a time.

---
 rtl/tx_sched_if.sv | 39 +++
 rtl/tx_packet_scheduler.sv | 166 ++++++++++++++++
 tb/tb_tx_packet_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_sched_if.sv
// Bundle of requester, payload-stream and generator-control signals around tx_packet_scheduler.
// master = scheduler side, slave = requesters / generator side.
interface tx_sched_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DESC_W = 256
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DESC_W-1:0] req_desc;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ*32-1:0]     s_axis_tdata;
    logic [N_REQ*4-1:0]      s_axis_tkeep;
    logic [N_REQ-1:0]        s_axis_tvalid;
    logic [N_REQ-1:0]        s_axis_tlast;
    logic [N_REQ-1:0]        s_axis_tready;
    logic [31:0]             m_axis_tdata;
    logic [3:0]              m_axis_tkeep;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic                    m_axis_tready;
    logic [DESC_W-1:0]       gen_desc;
    logic                    gen_valid;
    logic                    gen_ready;
    logic                    gen_flush;
    logic [31:0]             pkt_count;

    modport master (
        input  req, req_desc, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
               m_axis_tready, gen_ready,
        output grant, s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
               gen_desc, gen_valid, gen_flush, pkt_count
    );

    modport slave (
        output req, req_desc, s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
               m_axis_tready, gen_ready,
        input  grant, s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
               gen_desc, gen_valid, gen_flush, pkt_count
    );
endinterface

// File: rtl/tx_packet_scheduler.sv
// Round-robin arbiter sharing one packet generator among N_REQ payload sources, one packet in flight.
// Optional payload stall timeout with generator flush: define TX_SCHED_TIMEOUT_EN.
module tx_packet_scheduler #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DESC_W         = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic      axis_clk,
    input  logic      axis_resetn,
    tx_sched_if.master bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, LAUNCH, WAIT_DONE} state_e;

    state_e             state, state_nxt;
    logic [N_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]   gidx_q, rr_ptr_q, pick_idx, rr_next;
    logic [SUM_W-1:0]   scan_sum;
    logic [DESC_W-1:0]  gen_desc_q, pick_desc;
    logic [31:0]        pkt_count_q;
    logic               gen_valid_q, seen_busy_q, pick_found;
    logic [31:0]        sel_tdata;
    logic [3:0]         sel_tkeep;
    logic               sel_tvalid, sel_tlast;
    logic               stream_c, beat_c, last_beat_c, timeout_c, done_c;

    // Rotating scan from rr_ptr; descending loop so the smallest offset wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        pick_desc  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_sum = SUM_W'(rr_ptr_q) + SUM_W'(k);
            if (scan_sum >= SUM_W'(N_REQ)) scan_sum = scan_sum - SUM_W'(N_REQ);
            if (bus.req[scan_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_sum[IDX_W-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++)
            if (pick_idx == IDX_W'(i)) pick_desc = bus.req_desc[i*DESC_W +: DESC_W];
    end

    assign rr_next = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // State register
    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) state <= IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_found) state_nxt = STREAM;
            STREAM: begin
                if (last_beat_c)    state_nxt = LAUNCH;
                else if (timeout_c) state_nxt = IDLE;
            end
            LAUNCH:    if (bus.gen_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_c) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output logic: payload mux from the registered grant index
    always_comb begin
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                sel_tdata  = bus.s_axis_tdata[i*32 +: 32];
                sel_tkeep  = bus.s_axis_tkeep[i*4 +: 4];
                sel_tvalid = bus.s_axis_tvalid[i];
                sel_tlast  = bus.s_axis_tlast[i];
            end
        end
    end

    assign stream_c          = (state == STREAM);
    assign bus.m_axis_tdata  = sel_tdata;
    assign bus.m_axis_tkeep  = sel_tkeep;
    assign bus.m_axis_tvalid = stream_c & sel_tvalid;
    assign bus.m_axis_tlast  = stream_c & sel_tlast;
    assign beat_c            = bus.m_axis_tvalid & bus.m_axis_tready;
    assign last_beat_c       = beat_c & sel_tlast;
    assign done_c            = (state == WAIT_DONE) & seen_busy_q & bus.gen_ready;
    // Timeout forces the owner's ready high for one cycle so a late beat is drained, not stranded.
    assign bus.s_axis_tready = (stream_c & (bus.m_axis_tready | timeout_c)) ? grant_q : '0;

    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            gen_desc_q  <= '0;
            gen_valid_q <= 1'b0;
            seen_busy_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    grant_q    <= N_REQ'(1) << pick_idx;
                    gidx_q     <= pick_idx;
                    gen_desc_q <= pick_desc;
                end
                STREAM: begin
                    if (last_beat_c) begin
                        gen_valid_q <= 1'b1;
                    end else if (timeout_c) begin
                        grant_q  <= '0;
                        rr_ptr_q <= rr_next;
                    end
                end
                LAUNCH: if (bus.gen_ready) gen_valid_q <= 1'b0;
                WAIT_DONE: begin
                    if (!bus.gen_ready) begin
                        seen_busy_q <= 1'b1;
                    end else if (seen_busy_q) begin
                        seen_busy_q <= 1'b0;
                        pkt_count_q <= pkt_count_q + 32'd1;
                        rr_ptr_q    <= rr_next;
                        grant_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TX_SCHED_TIMEOUT_EN
    logic [15:0] stall_cnt_q;
    logic        gen_flush_q;

    assign timeout_c = stream_c & ~beat_c & (stall_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // IDLE always precedes STREAM, so clearing there covers entry to STREAM.
    always_ff @(posedge axis_clk) begin
        if (!axis_resetn) begin
            stall_cnt_q <= '0;
            gen_flush_q <= 1'b0;
        end else begin
            gen_flush_q <= timeout_c;
            if (!stream_c || beat_c) stall_cnt_q <= '0;
            else                     stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.gen_flush = gen_flush_q;
`else
    assign timeout_c     = 1'b0;
    assign bus.gen_flush = 1'b0;
`endif

    assign bus.grant     = grant_q;
    assign bus.gen_desc  = gen_desc_q;
    assign bus.gen_valid = gen_valid_q;
    assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler: single packet, contention, wrap, stall, reset, optional timeout.
module tb_tx_packet_scheduler;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    tx_sched_if #(.N_REQ(4), .DESC_W(256)) bus ();

    tx_packet_scheduler #(.N_REQ(4), .DESC_W(256), .TIMEOUT_CYCLES(16)) dut (
        .axis_clk    (clk),
        .axis_resetn (rstn),
        .bus         (bus.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [255:0] desc_of(input int i);
        return {8{32'hDE5C_0000 + 32'(i)}};
    endfunction

    // Payload sources: data = {A0+i, 00, beat index}, last beat carries tkeep 4'h3
    logic [3:0]  src_en;
    logic [15:0] len  [4];
    logic [15:0] bidx [4] = '{default: 16'd0};

    for (genvar i = 0; i < 4; i++) begin : g_src
        assign bus.req_desc[i*256 +: 256]   = desc_of(i);
        assign bus.s_axis_tvalid[i]         = src_en[i];
        assign bus.s_axis_tlast[i]          = (bidx[i] == len[i] - 16'd1);
        assign bus.s_axis_tdata[i*32 +: 32] = {8'(160 + i), 8'h00, bidx[i]};
        assign bus.s_axis_tkeep[i*4 +: 4]   = bus.s_axis_tlast[i] ? 4'h3 : 4'hF;
    end

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (src_en[i] && bus.s_axis_tready[i])
                bidx[i] <= bus.s_axis_tlast[i] ? 16'd0 : bidx[i] + 16'd1;

    // Generator model: after a launch it is busy for three cycles
    logic       gen_hold;
    logic [1:0] busy = 2'd0;
    assign bus.gen_ready = !gen_hold && (busy == 2'd0);
    always @(posedge clk) begin
        if (bus.gen_valid && bus.gen_ready) busy <= 2'd3;
        else if (busy != 2'd0)              busy <= busy - 2'd1;
    end

    // Monitors
    logic [31:0] mon_data [$];
    logic [3:0]  mon_keep [$];
    logic        mon_last [$];
    logic [3:0]  grant_log [$];
    logic [3:0]  prev_grant = 4'd0;
    int          gv_cycles = 0;
    int          flush_cycles = 0;

    always @(posedge clk) begin
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            mon_data.push_back(bus.m_axis_tdata);
            mon_keep.push_back(bus.m_axis_tkeep);
            mon_last.push_back(bus.m_axis_tlast);
        end
        if (bus.grant != prev_grant && bus.grant != 4'd0) grant_log.push_back(bus.grant);
        prev_grant <= bus.grant;
        if (bus.gen_valid) gv_cycles <= gv_cycles + 1;
        if (bus.gen_flush) flush_cycles <= flush_cycles + 1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pkt(input logic [31:0] target, input int budget);
        int c = 0;
        while (bus.pkt_count !== target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("pkt_wait", 256'(bus.pkt_count), 256'(target));
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (grant_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("grant_wait", 256'(grant_log.size()), 256'(n));
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while (mon_data.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("beat_wait", 256'(mon_data.size()), 256'(n));
    endtask

    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int bb, gb, gv0, bad, c;
        rstn              = 1'b0;
        bus.req           = '0;
        bus.m_axis_tready = 1'b1;
        src_en            = '0;
        gen_hold          = 1'b0;
        for (int i = 0; i < 4; i++) len[i] = 16'd2;
        repeat (3) @(negedge clk);

        check("rst_grant",     256'(bus.grant),         256'(0));
        check("rst_gen_valid", 256'(bus.gen_valid),     256'(0));
        check("rst_gen_flush", 256'(bus.gen_flush),     256'(0));
        check("rst_pkt_count", 256'(bus.pkt_count),     256'(0));
        check("rst_gen_desc",  bus.gen_desc,            256'(0));
        check("rst_m_tvalid",  256'(bus.m_axis_tvalid), 256'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Single requester, 3 beats
        len[0] = 16'd3; src_en = 4'b0001; bus.req = 4'b0001;
        bb = mon_data.size(); gv0 = gv_cycles;
        @(negedge clk);
        check("single_grant",    256'(bus.grant),         256'(4'b0001));
        check("single_desc",     bus.gen_desc,            desc_of(0));
        check("single_s_tready", 256'(bus.s_axis_tready), 256'(4'b0001));
        check("single_m_tvalid", 256'(bus.m_axis_tvalid), 256'(1));
        bus.req = '0;
        wait_pkt(32'd1, 100);
        src_en = '0;
        check("single_nbeats", 256'(mon_data.size() - bb), 256'(3));
        for (int k = 0; k < 3; k++) begin
            check("single_data", 256'(mon_data[bb+k]), 256'(32'hA000_0000 + 32'(k)));
            check("single_keep", 256'(mon_keep[bb+k]), 256'((k == 2) ? 4'h3 : 4'hF));
            check("single_last", 256'(mon_last[bb+k]), 256'(k == 2));
        end
        check("single_gv_cycles", 256'(gv_cycles - gv0), 256'(1));

        // Fresh reset so contention starts from requester 0
        rstn = 1'b0;
        @(negedge clk);
        check("rerst_pkt_count", 256'(bus.pkt_count), 256'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Contention: all four request continuously
        for (int i = 0; i < 4; i++) len[i] = 16'd2;
        src_en = 4'b1111; bus.req = 4'b1111;
        gb = grant_log.size(); bb = mon_data.size();
        wait_grants(gb + 5, 200);
        bus.req = '0;
        wait_pkt(32'd5, 200);
        src_en = '0;
        for (int k = 0; k < 5; k++)
            check("rr_order", 256'(grant_log[gb+k]), 256'(exp_order[k]));
        check("rr_nbeats", 256'(mon_data.size() - bb), 256'(10));

        // Wrap: serve requester 1 alone (pointer -> 2), then 0 and 1 together
        src_en = 4'b0011; bus.req = 4'b0010;
        gb = grant_log.size();
        wait_grants(gb + 1, 20);
        bus.req = '0;
        wait_pkt(32'd6, 100);
        check("wrap_prep_grant", 256'(grant_log[gb]), 256'(4'b0010));
        bus.req = 4'b0011;
        gb = grant_log.size();
        wait_grants(gb + 2, 100);
        bus.req = '0;
        wait_pkt(32'd8, 100);
        src_en = '0;
        check("wrap_first",  256'(grant_log[gb]),   256'(4'b0001));
        check("wrap_second", 256'(grant_log[gb+1]), 256'(4'b0010));

        // Stall the generator side for 50 cycles mid-packet
        len[2] = 16'd4; src_en = 4'b0100; bus.req = 4'b0100;
        bb = mon_data.size();
        wait_beats(bb + 2, 50);
        bus.m_axis_tready = 1'b0;
        bus.req = '0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.grant !== 4'b0100)     bad++;
            if (bus.s_axis_tready !== 4'd0) bad++;
            if (bus.m_axis_tvalid !== 1'b1) bad++;
        end
        check("stall_violations", 256'(bad), 256'(0));
        check("stall_beats_held", 256'(mon_data.size() - bb), 256'(2));
        bus.m_axis_tready = 1'b1;
        wait_pkt(32'd9, 100);
        src_en = '0;
        check("stall_nbeats", 256'(mon_data.size() - bb), 256'(4));
        for (int k = 0; k < 4; k++) begin
            check("stall_data", 256'(mon_data[bb+k]), 256'(32'hA200_0000 + 32'(k)));
            check("stall_last", 256'(mon_last[bb+k]), 256'(k == 3));
        end

        // Reset while waiting for the generator to finish
        len[3] = 16'd2; src_en = 4'b1000; bus.req = 4'b1000;
        c = 0;
        while (bus.gen_valid !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("wd_launch_seen", 256'(bus.gen_valid), 256'(1));
        @(negedge clk);
        check("wd_gen_busy", 256'(bus.gen_ready), 256'(0));
        rstn = 1'b0; gen_hold = 1'b1; bus.req = '0; src_en = '0;
        @(negedge clk);
        check("wdrst_grant",     256'(bus.grant),     256'(0));
        check("wdrst_gen_valid", 256'(bus.gen_valid), 256'(0));
        check("wdrst_pkt_count", 256'(bus.pkt_count), 256'(0));
        rstn = 1'b1; gen_hold = 1'b0;
        @(negedge clk);
        len[0] = 16'd2; src_en = 4'b1001; bus.req = 4'b1001;
        gb = grant_log.size();
        wait_grants(gb + 1, 20);
        bus.req = '0;
        check("postrst_grant", 256'(grant_log[gb]), 256'(4'b0001));
        check("postrst_desc",  bus.gen_desc,        desc_of(0));
        wait_pkt(32'd1, 100);
        src_en = '0;
        check("no_flush_so_far", 256'(flush_cycles), 256'(0));

`ifdef TX_SCHED_TIMEOUT_EN
        // Source stops after 2 beats; flush expected after 16 idle cycles
        len[0] = 16'd5; src_en = 4'b0001; bus.req = 4'b0001;
        bb = mon_data.size();
        wait_beats(bb + 2, 50);
        src_en = '0; bus.req = '0;
        c = 0;
        while (bus.gen_flush !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("to_flush_delay", 256'(c),             256'(16));
        check("to_grant",       256'(bus.grant),     256'(0));
        check("to_pkt_count",   256'(bus.pkt_count), 256'(1));
        @(negedge clk);
        check("to_flush_pulse", 256'(flush_cycles), 256'(1));
        check("to_flush_low",   256'(bus.gen_flush), 256'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
